// File: rtl/rx_deframer.sv
// Link-side deframer: hunts for a sync word, validates a length header and forwards the payload
// as an AXI-Stream word stream with sof/eof. Optional trailer checksum: RX_DEFRAMER_CHECKSUM_EN.
module rx_deframer #(
  parameter logic [31:0] C_SYNC_WORD = 32'hA5C3_5AC3,
  parameter int unsigned C_MAX_LEN   = 1024
) (
  input  logic        i_aclk,
  input  logic        i_aresetn,
  input  logic        i_enable,
  output logic        s_axis_tready,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_sof,
  output logic        m_axis_eof,
  output logic        o_locked,
  output logic [15:0] o_frame_count,
  output logic [7:0]  o_hdr_err_count,
  output logic        o_checksum_err
);

  typedef enum logic [1:0] {S_HUNT, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] remaining;
  logic        first;
  logic [15:0] hdr_len;
  logic        hdr_ok;
  logic        in_acc;
  logic        hdr_accept;
  logic        hdr_reject;
  logic        pay_acc;
  logic        last_pay;
  logic        frame_done;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign hdr_len = s_axis_tdata[15:0];
  assign hdr_ok  = (s_axis_tdata[31:16] == ~hdr_len) && (hdr_len != 16'd0) &&
                   ({16'd0, hdr_len} <= C_MAX_LEN);

  // HUNT never loads the output register, so it can accept regardless of output occupancy.
  always_comb begin
    s_axis_tready = 1'b1;
    case (state)
      S_HUNT:    s_axis_tready = i_enable;
      S_PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready;
      default:   s_axis_tready = 1'b1;
    endcase
  end

  assign in_acc     = s_axis_tvalid && s_axis_tready;
  assign hdr_accept = in_acc && (state == S_HEADER) && hdr_ok;
  assign hdr_reject = in_acc && (state == S_HEADER) && !hdr_ok && (s_axis_tdata != C_SYNC_WORD);
  assign pay_acc    = in_acc && (state == S_PAYLOAD);
  assign last_pay   = pay_acc && (remaining == 16'd1);
  assign o_locked   = (state != S_HUNT);

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) state <= S_HUNT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT: begin
        if (in_acc && (s_axis_tdata == C_SYNC_WORD)) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (hdr_accept)      state_nxt = S_PAYLOAD;
        else if (hdr_reject) state_nxt = S_HUNT;
      end
      S_PAYLOAD: begin
`ifdef RX_DEFRAMER_CHECKSUM_EN
        if (last_pay) state_nxt = S_TRAILER;
`else
        if (last_pay) state_nxt = S_HUNT;
`endif
      end
`ifdef RX_DEFRAMER_CHECKSUM_EN
      S_TRAILER: begin
        if (in_acc) state_nxt = S_HUNT;
      end
`endif
      default: state_nxt = S_HUNT;
    endcase
  end

  // Output register stage: one accepted payload word is presented the following cycle.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      remaining       <= 16'd0;
      first           <= 1'b0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= 32'd0;
      m_axis_sof      <= 1'b0;
      m_axis_eof      <= 1'b0;
      o_frame_count   <= 16'd0;
      o_hdr_err_count <= 8'd0;
    end else begin
      if (hdr_accept) begin
        remaining <= hdr_len;
        first     <= 1'b1;
      end else if (pay_acc) begin
        remaining <= remaining - 16'd1;
        first     <= 1'b0;
      end
      if (pay_acc) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_sof    <= first;
        m_axis_eof    <= (remaining == 16'd1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (frame_done) o_frame_count <= o_frame_count + 16'd1;
      if (hdr_reject) o_hdr_err_count <= sat_inc8(o_hdr_err_count);
    end
  end

`ifdef RX_DEFRAMER_CHECKSUM_EN
  logic [31:0] checksum;
  logic        trl_acc;

  assign trl_acc    = in_acc && (state == S_TRAILER);
  assign frame_done = trl_acc && (s_axis_tdata == checksum);

  // Forwarded payload is never retracted; a bad trailer only flags and skips the frame count.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      checksum       <= 32'd0;
      o_checksum_err <= 1'b0;
    end else begin
      if (hdr_accept)   checksum <= 32'd0;
      else if (pay_acc) checksum <= checksum ^ s_axis_tdata;
      o_checksum_err <= trl_acc && (s_axis_tdata != checksum);
    end
  end
`else
  assign frame_done     = last_pay;
  assign o_checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: vector table, directed corner sequences and random traffic
// compared against a word-stream frame parser model.
module tb_rx_deframer;
  localparam logic [31:0] SYNC = 32'hA5C3_5AC3;
  localparam int          MAXL = 1024;
  localparam int M_HUNT = 0, M_HDR = 1, M_PAY = 2, M_TRL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic        mrdy = 1'b0;
  logic        s_tready, m_tvalid, m_sof, m_eof, locked, cerr;
  logic [31:0] m_tdata;
  logic [15:0] frame_count;
  logic [7:0]  hdr_err;

  rx_deframer #(.C_SYNC_WORD(SYNC), .C_MAX_LEN(MAXL)) dut (
    .i_aclk(clk), .i_aresetn(rst_n), .i_enable(en),
    .s_axis_tready(s_tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axis_tready(mrdy), .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata),
    .m_axis_sof(m_sof), .m_axis_eof(m_eof), .o_locked(locked),
    .o_frame_count(frame_count), .o_hdr_err_count(hdr_err), .o_checksum_err(cerr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] data; logic sof; logic eof;} beat_t;
  beat_t exp_q[$];
  int          mmode;
  int          mrem;
  logic        mfirst;
  logic [31:0] mcsum;
  int          mframes;
  int          merrs;
  logic        cerr_exp;
  logic        rand_mode = 1'b0;
  logic        bp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] make_hdr(input int len);
    logic [15:0] l;
    l = 16'(len);
    return {~l, l};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mmode = M_HUNT; mrem = 0; mfirst = 1'b0; mcsum = 32'd0;
    mframes = 0; merrs = 0; cerr_exp = 1'b0;
  endfunction

  // Frame parser over the accepted word stream; payload words queue up as expected output beats.
  function automatic void model_accept(input logic [31:0] w);
    beat_t b;
    int    len;
    case (mmode)
      M_HUNT: if (w == SYNC) mmode = M_HDR;
      M_HDR: begin
        len = int'(w[15:0]);
        if (w[31:16] == ~w[15:0] && len >= 1 && len <= MAXL) begin
          mrem = len; mfirst = 1'b1; mcsum = 32'd0; mmode = M_PAY;
        end else if (w != SYNC) begin
          if (merrs < 255) merrs++;
          mmode = M_HUNT;
        end
      end
      M_PAY: begin
        b.data = w; b.sof = mfirst; b.eof = (mrem == 1);
        exp_q.push_back(b);
        mfirst = 1'b0; mcsum ^= w; mrem--;
        if (mrem == 0) begin
`ifdef RX_DEFRAMER_CHECKSUM_EN
          mmode = M_TRL;
`else
          mframes = (mframes + 1) % 65536;
          mmode = M_HUNT;
`endif
        end
      end
      default: begin
        if (w == mcsum) mframes = (mframes + 1) % 65536;
        else            cerr_exp = 1'b1;
        mmode = M_HUNT;
      end
    endcase
  endfunction

  // One clock: inputs already driven; sample handshakes before the edge, check state after it.
  task automatic step(output logic acc);
    logic        xfer, stall, exp_rdy;
    logic [31:0] held;
    if (bp_q.size() > 0) mrdy = bp_q.pop_front();
    else if (rand_mode) begin
      mrdy = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 7) != 0);
    end
    #2;
    if (mmode == M_HUNT)     exp_rdy = en;
    else if (mmode == M_PAY) exp_rdy = !m_tvalid || mrdy;
    else                     exp_rdy = 1'b1;
    chk("s_axis_tready", s_tready, exp_rdy);
    acc   = tvalid && s_tready;
    xfer  = m_tvalid && mrdy;
    stall = m_tvalid && !mrdy;
    held  = m_tdata;
    @(posedge clk);
    cerr_exp = 1'b0;
    if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) model_accept(tdata);
    #1;
    if (stall) begin
      chk("hold_tvalid", m_tvalid, 1);
      chk("hold_tdata", m_tdata, held);
    end
    chk("m_axis_tvalid", m_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("m_axis_tdata", m_tdata, exp_q[0].data);
      chk("m_axis_sof", m_sof, exp_q[0].sof);
      chk("m_axis_eof", m_eof, exp_q[0].eof);
    end
    chk("o_locked", locked, mmode != M_HUNT);
    chk("o_frame_count", frame_count, mframes);
    chk("o_hdr_err_count", hdr_err, merrs);
    chk("o_checksum_err", cerr, cerr_exp);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic acc, ok;
    if (rand_mode) begin
      tvalid = 1'b0;
      repeat ($urandom_range(0, 1)) step(acc);
    end
    tvalid = 1'b1; tdata = w; ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step(acc);
      ok = acc;
    end
    tvalid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: word %h not accepted, required within 200 cycles", w);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    tvalid = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic send_body(input int len, input logic [31:0] pay[$]);
    send_word(SYNC);
    send_word(make_hdr(len));
    foreach (pay[i]) send_word(pay[i]);
  endtask

  task automatic send_frame(input int len, input logic [31:0] pay[$], input logic bad_trl);
    logic [31:0] x;
    x = 32'd0;
    foreach (pay[i]) x ^= pay[i];
    send_body(len, pay);
`ifdef RX_DEFRAMER_CHECKSUM_EN
    send_word(bad_trl ? ~x : x);
`else
    if (bad_trl) x = ~x;
`endif
  endtask

`ifndef RX_DEFRAMER_CHECKSUM_EN
  typedef struct {
    logic tv; logic [31:0] din;
    logic mv; logic [31:0] dout; logic sof; logic eof; logic lk; logic [15:0] fr; logic [7:0] er;
  } vec_t;
  vec_t tbl[23];
`endif

  initial begin
    logic        acc;
    logic [31:0] pay[$];
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_sof", m_sof, 0);
    chk("rst_eof", m_eof, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_hdr_err", hdr_err, 0);
    chk("rst_cerr", cerr, 0);
    chk("rst_tready", s_tready, 0);
    rst_n = 1'b1; en = 1'b1; mrdy = 1'b1;
    @(posedge clk);
    #1;

`ifndef RX_DEFRAMER_CHECKSUM_EN
    // Good 3-word frame, bad header + 1-word frame, length boundaries and sync re-sync.
    tbl[0]  = '{1, 32'h12345678, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, SYNC,         0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 32'hFFFC0003, 0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 32'h00000001, 1, 32'h00000001, 1, 0, 1, 0, 0};
    tbl[4]  = '{1, 32'h00000002, 1, 32'h00000002, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 32'h00000003, 1, 32'h00000003, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 32'h0,        0, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{1, SYNC,         0, 0, 0, 0, 1, 1, 0};
    tbl[8]  = '{1, 32'h00000005, 0, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{1, SYNC,         0, 0, 0, 0, 1, 1, 1};
    tbl[10] = '{1, 32'hFFFE0001, 0, 0, 0, 0, 1, 1, 1};
    tbl[11] = '{1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 1, 0, 2, 1};
    tbl[12] = '{0, 32'h0,        0, 0, 0, 0, 0, 2, 1};
    tbl[13] = '{1, SYNC,         0, 0, 0, 0, 1, 2, 1};
    tbl[14] = '{1, 32'hFFFF0000, 0, 0, 0, 0, 0, 2, 2};
    tbl[15] = '{1, SYNC,         0, 0, 0, 0, 1, 2, 2};
    tbl[16] = '{1, 32'hFBFE0401, 0, 0, 0, 0, 0, 2, 3};
    tbl[17] = '{1, SYNC,         0, 0, 0, 0, 1, 2, 3};
    tbl[18] = '{1, SYNC,         0, 0, 0, 0, 1, 2, 3};
    tbl[19] = '{1, 32'hFFFD0002, 0, 0, 0, 0, 1, 2, 3};
    tbl[20] = '{1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 0, 1, 2, 3};
    tbl[21] = '{1, SYNC,         1, SYNC, 0, 1, 0, 3, 3};
    tbl[22] = '{0, 32'h0,        0, 0, 0, 0, 0, 3, 3};
    for (int i = 0; i < 23; i++) begin
      tvalid = tbl[i].tv; tdata = tbl[i].din;
      step(acc);
      chk($sformatf("tbl%0d_tvalid", i), m_tvalid, tbl[i].mv);
      if (tbl[i].mv) begin
        chk($sformatf("tbl%0d_tdata", i), m_tdata, tbl[i].dout);
        chk($sformatf("tbl%0d_sof", i), m_sof, tbl[i].sof);
        chk($sformatf("tbl%0d_eof", i), m_eof, tbl[i].eof);
      end
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_frames", i), frame_count, tbl[i].fr);
      chk($sformatf("tbl%0d_hdr_err", i), hdr_err, tbl[i].er);
    end
    tvalid = 1'b0;
`else
    // Trailer match then trailer mismatch on the same payload.
    pay = '{32'h1, 32'h2};
    send_body(2, pay);
    send_word(32'h3);
    chk("ck_good_cerr", cerr, 0);
    idle(2);
    chk("ck_good_frames", frame_count, 1);
    send_body(2, pay);
    send_word(32'h0);
    chk("ck_bad_pulse", cerr, 1);
    idle(1);
    chk("ck_bad_pulse_end", cerr, 0);
    chk("ck_bad_frames", frame_count, 1);
    idle(2);
`endif

    // Backpressure across a 4-word frame.
    send_word(SYNC);
    send_word(make_hdr(4));
    bp_q = '{1, 0, 0, 1, 0, 1};
    send_word(32'h11); send_word(32'h22); send_word(32'h33); send_word(32'h44);
    pay.delete();
`ifdef RX_DEFRAMER_CHECKSUM_EN
    send_word(32'h11 ^ 32'h22 ^ 32'h33 ^ 32'h44);
`endif
    idle(3);
    chk("bp_drained", exp_q.size(), 0);

    // Reset after the 2nd payload word of a 4-word frame.
    send_word(SYNC);
    send_word(make_hdr(4));
    send_word(32'h55); send_word(32'h66);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_sof", m_sof, 0);
    chk("mid_rst_eof", m_eof, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_frames", frame_count, 0);
    chk("mid_rst_hdr_err", hdr_err, 0);
    chk("mid_rst_cerr", cerr, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(32'h77); send_word(32'h88);
    chk("post_rst_locked", locked, 0);
    pay = '{32'h99, 32'hAA};
    send_frame(2, pay, 1'b0);
    idle(2);
    chk("post_rst_frames", frame_count, 1);

    // Header error counter saturation.
    repeat (260) begin
      send_word(SYNC);
      send_word(32'h0000_0005);
    end
    chk("hdr_err_sat", hdr_err, 8'hFF);

    // Randomized traffic, including one maximum-length frame.
    rand_mode = 1'b1;
    pay.delete();
    for (int i = 0; i < MAXL; i++) pay.push_back($urandom);
    send_frame(MAXL, pay, 1'b0);
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1: send_word($urandom);
        2: begin
          send_word(SYNC);
          case ($urandom_range(0, 3))
            0: send_word($urandom);
            1: send_word(32'hFFFF0000);
            2: send_word(make_hdr(MAXL + 1));
            default: send_word(32'h0000_0005);
          endcase
        end
        default: begin
          int len;
          len = $urandom_range(1, 6);
          pay.delete();
          for (int k = 0; k < len; k++)
            pay.push_back(($urandom_range(0, 7) == 0) ? SYNC : $urandom);
          send_frame(len, pay, $urandom_range(0, 3) == 0);
        end
      endcase
    end
    rand_mode = 1'b0; mrdy = 1'b1; en = 1'b1;
    idle(4);
    chk("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
